// File: rtl/lcd_fmt_pkg.sv
// lcd_fmt_pkg: ASCII constants and hex-digit rendering shared by the LCD frame formatter.
package lcd_fmt_pkg;
  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] DASH = 8'h2D;
  localparam logic [7:0] ZERO = 8'h30;
  localparam int LINE_CHARS = 16;
  function automatic logic [7:0] hex2ascii(input logic [3:0] n);
    return (n < 4'd10) ? ZERO + {4'd0, n} : 8'h37 + {4'd0, n};
  endfunction
endpackage

// File: rtl/lcd_probe_formatter_hex_field.sv
// hex_field: renders an N-digit hex value as N uppercase ASCII bytes, most significant digit first.
module hex_field
  import lcd_fmt_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [4*N-1:0] val_i,
  output logic [8*N-1:0] ascii_o
);
  genvar d;
  generate
    for (d = 0; d < N; d++) begin : g_d
      assign ascii_o[8*d +: 8] = hex2ascii(val_i[4*d +: 4]);
    end
  endgenerate
endmodule

// File: rtl/lcd_probe_formatter.sv
// lcd_probe_formatter: snapshots probes/register readout on single-step and renders a paged 16x2 ASCII frame.
module lcd_probe_formatter
  import lcd_fmt_pkg::*;
#(
  parameter int NUM_CH = 9,
  parameter int CNT_W  = 8
) (
  input  logic                  CCLK,
  input  logic                  rst,
  input  logic                  step,
  input  logic                  clr,
  input  logic                  page,
  input  logic [3:0]            sel,
  input  logic [32*NUM_CH-1:0]  probes,
  input  logic [31:0]           reg_value,
  output logic [255:0]          strdata,
  output logic                  cls,
  output logic [CNT_W-1:0]      step_cnt,
  output logic [3:0]            page_idx
);
  localparam int NUM_PAGES = (NUM_CH + 2) / 4;
  logic [32*NUM_CH-1:0] snap_q;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0] reg_q;
  logic [3:0] sel_q, page_q, v_page;
  logic ev_q, init_q, cls_q;
  logic [16*LINE_CHARS-1:0] str_q, str_d;
  logic snap_en, reg_en, ev_d;
  logic [31:0] v_ch0;
  logic [7:0] v_cnt;
  logic [15:0] v_reg;
  logic [63:0] a_ch0;
  logic [15:0] a_cnt;
  logic [31:0] a_reg;
  logic [31:0] fld [4];
  logic unused_ok;
  assign snap_en = step | clr;
  assign reg_en = snap_en | (sel != sel_q);
  assign ev_d = reg_en | page;
  // While in reset the frame is rendered from an all-zero view so the reset frame lands immediately.
  assign v_ch0 = rst ? 32'd0 : snap_q[31:0];
  assign v_cnt = rst ? 8'd0 : cnt_q[7:0];
  assign v_reg = rst ? 16'd0 : reg_q;
  assign v_page = rst ? 4'd0 : page_q;
  hex_field #(.N(8)) u_ch0 (.val_i(v_ch0), .ascii_o(a_ch0));
  hex_field #(.N(2)) u_cnt (.val_i(v_cnt), .ascii_o(a_cnt));
  hex_field #(.N(4)) u_reg (.val_i(v_reg), .ascii_o(a_reg));
  genvar f;
  generate
    for (f = 0; f < 4; f++) begin : g_f
      logic [5:0] ch;
      logic [7:0] pb;
      logic [15:0] a_pb;
      assign ch = 6'd1 + {v_page, 2'b00} + 6'(f);
      always_comb begin
        pb = 8'd0;
        for (int k = 1; k < NUM_CH; k++) pb = (ch == 6'(k) && !rst) ? snap_q[32*k +: 8] : pb;
      end
      hex_field #(.N(2)) u_pb (.val_i(pb), .ascii_o(a_pb));
      assign fld[f] = (ch < 6'(NUM_CH)) ? {hex2ascii(ch[3:0]), a_pb, SPACE} : {DASH, DASH, DASH, SPACE};
    end
  endgenerate
  assign str_d = {a_ch0, SPACE, a_cnt, SPACE, a_reg, fld[0], fld[1], fld[2], fld[3]};
  always_ff @(posedge CCLK) begin
    if (rst) begin
      snap_q <= '0;
      cnt_q <= '0;
      reg_q <= '0;
      sel_q <= '0;
      page_q <= '0;
      ev_q <= 1'b0;
      init_q <= 1'b1;
      cls_q <= 1'b0;
      str_q <= str_d;
    end else begin
      if (snap_en) snap_q <= probes;
      if (clr) cnt_q <= '0;
      else if (step) cnt_q <= cnt_q + 1'b1;
      if (reg_en) begin
        reg_q <= reg_value[15:0];
        sel_q <= sel;
      end
      if (page) page_q <= (page_q == 4'(NUM_PAGES - 1)) ? 4'd0 : page_q + 4'd1;
      ev_q <= ev_d;
      init_q <= 1'b0;
      cls_q <= ev_q | init_q;
      str_q <= str_d;
    end
  end
  assign unused_ok = ^{snap_q, reg_value[31:16]};
  assign strdata = str_q;
  assign cls = cls_q;
  assign step_cnt = cnt_q;
  assign page_idx = page_q;
endmodule

// File: tb/tb_lcd_probe_formatter.sv
// tb_lcd_probe_formatter: table-driven and randomized checks of two formatter instances (9 and 6 channels).
module tb_lcd_probe_formatter;
  logic clk = 1'b0, rst = 1'b1, step = 1'b0, clr = 1'b0, page = 1'b0;
  logic [3:0] sel = 4'd0;
  logic [32*9-1:0] probes = '0;
  logic [31:0] reg_value = 32'd0;
  logic [255:0] sd9, sd6;
  logic cls9, cls6;
  logic [7:0] sc9, sc6;
  logic [3:0] pi9, pi6;
  int checks = 0, fails = 0;
  logic [31:0] m_snap [9];
  int m_cnt, m_pg9, m_pg6;
  logic [15:0] m_reg;
  logic [3:0] m_sel;
  bit m_pend, m_init;

  always #5 clk = ~clk;

  lcd_probe_formatter #(.NUM_CH(9), .CNT_W(8)) dut9 (
    .CCLK(clk), .rst(rst), .step(step), .clr(clr), .page(page), .sel(sel),
    .probes(probes), .reg_value(reg_value), .strdata(sd9), .cls(cls9),
    .step_cnt(sc9), .page_idx(pi9));
  lcd_probe_formatter #(.NUM_CH(6), .CNT_W(8)) dut6 (
    .CCLK(clk), .rst(rst), .step(step), .clr(clr), .page(page), .sel(sel),
    .probes(probes[191:0]), .reg_value(reg_value), .strdata(sd6), .cls(cls6),
    .step_cnt(sc6), .page_idx(pi6));

  function automatic logic [7:0] hc(int n);
    return (n < 10) ? 8'(48 + n) : 8'(55 + n);
  endfunction

  function automatic logic [255:0] render(int nch, int pg);
    logic [7:0] c [32];
    logic [255:0] r;
    for (int i = 0; i < 8; i++) c[i] = hc(int'((m_snap[0] >> (28 - 4*i)) & 32'hF));
    c[8] = 8'h20;
    c[9] = hc((m_cnt / 16) % 16);
    c[10] = hc(m_cnt % 16);
    c[11] = 8'h20;
    for (int i = 0; i < 4; i++) c[12+i] = hc(int'((m_reg >> (12 - 4*i)) & 16'hF));
    for (int f = 0; f < 4; f++) begin
      int ch, b;
      ch = 1 + 4*pg + f;
      b = 16 + 4*f;
      if (ch < nch) begin
        c[b] = hc(ch % 16);
        c[b+1] = hc(int'(m_snap[ch][7:4]));
        c[b+2] = hc(int'(m_snap[ch][3:0]));
      end else begin
        c[b] = 8'h2D; c[b+1] = 8'h2D; c[b+2] = 8'h2D;
      end
      c[b+3] = 8'h20;
    end
    for (int i = 0; i < 32; i++) r[255-8*i -: 8] = c[i];
    return r;
  endfunction

  function automatic logic [127:0] s2b(string s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
    return r;
  endfunction

  task automatic chk(string n, logic [255:0] a, logic [255:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask

  task automatic tick();
    logic [255:0] e9, e6;
    bit ecls, ev;
    @(posedge clk);
    #1;
    if (rst) begin
      for (int k = 0; k < 9; k++) m_snap[k] = 32'd0;
      m_cnt = 0; m_reg = 16'd0; m_sel = 4'd0; m_pg9 = 0; m_pg6 = 0;
      e9 = render(9, 0); e6 = render(6, 0);
      ecls = 1'b0; m_pend = 1'b0; m_init = 1'b1;
    end else begin
      e9 = render(9, m_pg9); e6 = render(6, m_pg6);
      ecls = m_pend | m_init;
      ev = step | clr | page | (sel != m_sel);
      if (step | clr) for (int k = 0; k < 9; k++) m_snap[k] = probes[32*k +: 32];
      m_cnt = clr ? 0 : step ? (m_cnt + 1) % 256 : m_cnt;
      if (step | clr | (sel != m_sel)) begin
        m_reg = reg_value[15:0];
        m_sel = sel;
      end
      if (page) begin
        m_pg9 = (m_pg9 + 1) % ((9 + 2) / 4);
        m_pg6 = (m_pg6 + 1) % ((6 + 2) / 4);
      end
      m_pend = ev; m_init = 1'b0;
    end
    chk("strdata9", sd9, e9);
    chk("strdata6", sd6, e6);
    chk("cls9", 256'(cls9), 256'(ecls));
    chk("cls6", 256'(cls6), 256'(ecls));
    chk("step_cnt9", 256'(sc9), 256'(m_cnt));
    chk("step_cnt6", 256'(sc6), 256'(m_cnt));
    chk("page_idx9", 256'(pi9), 256'(m_pg9));
    chk("page_idx6", 256'(pi6), 256'(m_pg6));
  endtask

  typedef struct {
    bit st, cl, pg;
    logic [3:0] sel;
    logic [31:0] ch0, rv;
    string l1, l2a, l2b;
    int cnt, pgi;
  } vec_t;
  vec_t tbl [8];

  initial begin
    logic [255:0] rst_frame;
    tbl[0] = '{1, 0, 0, 4'd0, 32'h2002000A, 32'h1234, "2002000A 01 1234", "15C 222 333 444 ", "15C 222 333 444 ", 1, 0};
    tbl[1] = '{0, 0, 1, 4'd0, 32'h2002000A, 32'h1234, "2002000A 01 1234", "555 666 777 888 ", "555 --- --- --- ", 1, 1};
    tbl[2] = '{0, 0, 1, 4'd0, 32'h2002000A, 32'h1234, "2002000A 01 1234", "15C 222 333 444 ", "15C 222 333 444 ", 1, 0};
    tbl[3] = '{0, 0, 1, 4'd0, 32'h2002000A, 32'h1234, "2002000A 01 1234", "555 666 777 888 ", "555 --- --- --- ", 1, 1};
    tbl[4] = '{0, 0, 0, 4'd3, 32'h2002000A, 32'hBEEF, "2002000A 01 BEEF", "555 666 777 888 ", "555 --- --- --- ", 1, 1};
    tbl[5] = '{0, 0, 0, 4'd7, 32'h2002000A, 32'hCAFE, "2002000A 01 CAFE", "555 666 777 888 ", "555 --- --- --- ", 1, 1};
    tbl[6] = '{1, 1, 0, 4'd7, 32'hDEADBEEF, 32'hCAFE, "DEADBEEF 00 CAFE", "555 666 777 888 ", "555 --- --- --- ", 0, 1};
    tbl[7] = '{0, 1, 1, 4'd7, 32'h12345678, 32'hCAFE, "12345678 00 CAFE", "15C 222 333 444 ", "15C 222 333 444 ", 0, 0};
    rst_frame = {s2b("00000000 00 0000"), s2b("100 200 300 400 ")};
    probes[31:0] = 32'h2002000A;
    probes[63:32] = 32'h5C;
    for (int k = 2; k < 9; k++) probes[32*k +: 32] = 32'(k * 'h11);
    reg_value = 32'h1234;
    tick(); tick();
    chk("reset_frame", sd9, rst_frame);
    chk("reset_cls", 256'(cls9), 256'(0));
    rst = 1'b0;
    tick();
    chk("release_cls", 256'(cls9), 256'(1));
    tick();
    chk("release_cls_once", 256'(cls9), 256'(0));
    for (int i = 0; i < 8; i++) begin
      step = tbl[i].st; clr = tbl[i].cl; page = tbl[i].pg; sel = tbl[i].sel;
      probes[31:0] = tbl[i].ch0; reg_value = tbl[i].rv;
      tick();
      step = 1'b0; clr = 1'b0; page = 1'b0;
      tick();
      chk($sformatf("vec%0d_line1", i), 256'(sd9[255:128]), 256'(s2b(tbl[i].l1)));
      chk($sformatf("vec%0d_line2_9ch", i), 256'(sd9[127:0]), 256'(s2b(tbl[i].l2a)));
      chk($sformatf("vec%0d_line2_6ch", i), 256'(sd6[127:0]), 256'(s2b(tbl[i].l2b)));
      chk($sformatf("vec%0d_cls", i), 256'(cls9), 256'(1));
      chk($sformatf("vec%0d_cnt", i), 256'(sc9), 256'(tbl[i].cnt));
      chk($sformatf("vec%0d_page", i), 256'(pi9), 256'(tbl[i].pgi));
    end
    step = 1'b1;
    for (int i = 0; i < 255; i++) tick();
    step = 1'b0;
    tick(); tick();
    chk("preload_cnt", 256'(sc9), 256'(255));
    chk("preload_digits", 256'(sd9[183:168]), 256'(16'h4646));
    step = 1'b1; tick(); step = 1'b0; tick();
    chk("wrap_cnt", 256'(sc9), 256'(0));
    chk("wrap_digits", 256'(sd9[183:168]), 256'(16'h3030));
    chk("wrap_cls", 256'(cls9), 256'(1));
    step = 1'b1; tick(); step = 1'b0; rst = 1'b1; tick();
    chk("rst_mid_cls", 256'(cls9), 256'(0));
    chk("rst_mid_frame", sd9, rst_frame);
    chk("rst_mid_cnt", 256'(sc9), 256'(0));
    chk("rst_mid_page", 256'(pi9), 256'(0));
    sel = 4'd0; rst = 1'b0; tick();
    chk("rst_mid_release_cls", 256'(cls9), 256'(1));
    for (int i = 0; i < 400; i++) begin
      step = ($urandom % 4) == 0;
      clr = ($urandom % 16) == 0;
      page = ($urandom % 8) == 0;
      if (($urandom % 10) == 0) sel = 4'($urandom);
      for (int k = 0; k < 9; k++) probes[32*k +: 32] = $urandom;
      reg_value = $urandom;
      rst = ($urandom % 60) == 0;
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
